uart_tx_sched: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_sched.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and
// frame timing constants.
package uart_pkg;

  localparam int UART_BIT_CLKS   = 16;
  localparam int UART_FRAME_BITS = 11;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_CLKS = UART_BIT_CLKS * UART_FRAME_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GAP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr,
// wrapping around. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise the
    // conditional assignments below would infer latches.
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ producers.
// Optional WAIT watchdog with err_timeout output: define UART_SCHED_TIMEOUT_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int GAP_CYC     = UART_BIT_CLKS,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      clk1,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   data_in,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          done,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  input  logic                      tx_done
`ifdef UART_SCHED_TIMEOUT_EN
  ,
  output logic                      err_timeout
`endif
);

  localparam int IDX_W    = $clog2(N_REQ);
  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam sched_state_t POST_FRAME = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("N_REQ must be in 2..8");
  end
  if (TIMEOUT_CYC <= UART_FRAME_CLKS) begin : g_bad_timeout
    $error("TIMEOUT_CYC must exceed one full frame");
  end

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              tx_start_q, tx_start_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [N_REQ-1:0]  owner_hot;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign owner_hot = N_REQ'(1) << owner_q;

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    gnt_d      = '0;
    done_d     = '0;
    tx_start_d = 1'b0;
    gap_cnt_d  = gap_cnt_q;
`ifdef UART_SCHED_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (arb_valid && !tx_busy) begin
          state_d    = S_LOAD;
          gnt_d      = arb_gnt;
          tx_start_d = 1'b1;
          owner_d    = arb_idx;
          tx_data_d  = DATA_W'(data_in >> (int'(arb_idx) * DATA_W));
          ptr_d      = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
      end
      S_LOAD: begin
        // tx_done seen here belongs to no frame of ours and is dropped.
        state_d = S_WAIT;
`ifdef UART_SCHED_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (tx_done) begin
          done_d    = owner_hot;
          state_d   = POST_FRAME;
          gap_cnt_d = '0;
        end
`ifdef UART_SCHED_TIMEOUT_EN
        else if (wait_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          done_d    = owner_hot;
          err_d     = 1'b1;
          state_d   = POST_FRAME;
          gap_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      tx_data_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      tx_start_q <= tx_start_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err_timeout = err_q;
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign owner    = owner_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized
// traffic against a timestamp-level reference model of the scheduling rules.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int GAP = 16;
  localparam int TO  = 256;
  localparam int IW  = $clog2(N);
  localparam int FRAME = UART_BIT_CLKS * UART_FRAME_BITS;

  logic           clk1 = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data_in = '0;
  logic [N-1:0]   gnt, done;
  logic [IW-1:0]  owner;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic           tx_busy = 1'b0;
  logic           tx_done = 1'b0;
  logic           err_obs;

  uart_tx_sched #(
    .N_REQ(N), .DATA_W(W), .GAP_CYC(GAP), .TIMEOUT_CYC(TO)
  ) dut (
    .clk1(clk1), .reset(reset), .req(req), .data_in(data_in),
    .gnt(gnt), .done(done), .owner(owner), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
`ifdef UART_SCHED_TIMEOUT_EN
    , .err_timeout(err_obs)
`endif
  );
`ifndef UART_SCHED_TIMEOUT_EN
  assign err_obs = 1'b0;
`endif

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state (timestamps, not FSM states).
  int           m_ptr, m_owner, m_earliest;
  logic [W-1:0] m_txdata;
  bit           frame_on;
  int           grant_cycle, frame_end;
  logic [N-1:0] e_gnt, e_done;
  bit           e_start, e_err;

  // Stimulus knobs.
  logic [N-1:0]   req_v;
  logic [N*W-1:0] data_v;
  bit             busy_force, spur_en, withhold;
  int             frame_len;

  // Observed event log.
  int           g_idx[$], g_cyc[$], d_idx[$], d_cyc[$], err_cyc[$];
  logic [W-1:0] g_data[$];

  function automatic int first_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (((v >> i) & N'(1)) != '0) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    g_idx.delete(); g_cyc.delete(); g_data.delete();
    d_idx.delete(); d_cyc.delete(); err_cyc.delete();
  endtask

  // Drive one cycle of inputs, predict the next cycle, then compare.
  task automatic tick();
    logic [N-1:0] n_gnt, n_done;
    bit n_start, n_err, tdone_v, busy_v;
    int w, j;
    n_gnt = '0; n_done = '0; n_start = 0; n_err = 0;
    tdone_v = frame_on && !withhold && (cyc == frame_end);
    if (spur_en && frame_on && cyc == grant_cycle) tdone_v = 1;
    busy_v = busy_force || (frame_on && cyc >= grant_cycle && cyc <= frame_end);
    req = req_v; data_in = data_v; tx_busy = busy_v; tx_done = tdone_v;

    if (frame_on && cyc > grant_cycle && tdone_v) begin
      n_done = N'(1) << m_owner;
      frame_on = 0;
      m_earliest = cyc + 1 + GAP;
    end
`ifdef UART_SCHED_TIMEOUT_EN
    else if (frame_on && cyc == grant_cycle + TO) begin
      n_done = N'(1) << m_owner;
      n_err = 1;
      frame_on = 0;
      m_earliest = cyc + 1 + GAP;
    end
`endif
    else if (!frame_on && cyc >= m_earliest && req_v != '0 && !busy_v) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (w < 0 && ((req_v >> j) & N'(1)) != '0) w = j;
      end
      n_gnt = N'(1) << w;
      n_start = 1;
      m_owner = w;
      m_txdata = W'(data_v >> (w * W));
      m_ptr = (w + 1) % N;
      frame_on = 1;
      grant_cycle = cyc + 1;
      frame_end = withhold ? grant_cycle + TO : grant_cycle + frame_len;
      m_earliest = 32'h7fff_ffff;
      req_v = req_v & ~(N'(1) << w);
    end

    @(posedge clk1);
    @(negedge clk1);
    e_gnt = n_gnt; e_done = n_done; e_start = n_start; e_err = n_err;

    checks++;
    if (gnt !== e_gnt) begin
      errors++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, gnt, e_gnt);
    end
    checks++;
    if (tx_start !== e_start) begin
      errors++; $display("FAIL tx_start cyc=%0d got=%b exp=%b", cyc, tx_start, e_start);
    end
    checks++;
    if (done !== e_done) begin
      errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, e_done);
    end
    checks++;
    if (owner !== IW'(m_owner)) begin
      errors++; $display("FAIL owner cyc=%0d got=%0d exp=%0d", cyc, owner, m_owner);
    end
    checks++;
    if (tx_data !== m_txdata) begin
      errors++; $display("FAIL tx_data cyc=%0d got=%h exp=%h", cyc, tx_data, m_txdata);
    end
    checks++;
    if (err_obs !== e_err) begin
      errors++; $display("FAIL err_timeout cyc=%0d got=%b exp=%b", cyc, err_obs, e_err);
    end

    if (gnt != '0) begin
      g_idx.push_back(first_idx(gnt)); g_cyc.push_back(cyc); g_data.push_back(tx_data);
    end
    if (done != '0) begin
      d_idx.push_back(first_idx(done)); d_cyc.push_back(cyc);
    end
    if (err_obs) err_cyc.push_back(cyc);
  endtask

  task automatic apply_reset(int hold);
    @(negedge clk1);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (gnt !== '0 || done !== '0 || tx_start !== 1'b0 || err_obs !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses got gnt=%b done=%b start=%b err=%b exp all 0",
               gnt, done, tx_start, err_obs);
    end
    checks++;
    if (owner !== '0 || tx_data !== '0) begin
      errors++; $display("FAIL reset_regs got owner=%0d tx_data=%h exp 0/00", owner, tx_data);
    end
    req_v = '0; req = '0; tx_busy = 1'b0; tx_done = 1'b0;
    busy_force = 0; spur_en = 0; withhold = 0;
    m_ptr = 0; m_owner = 0; m_txdata = '0; frame_on = 0;
    grant_cycle = -10; frame_end = -10;
    repeat (hold) @(negedge clk1);
    reset = 1'b1;
    m_earliest = cyc;
  endtask

  // Run with no requests until the model says the scheduler is idle again.
  task automatic drain();
    int n = 0;
    req_v = '0; busy_force = 0; spur_en = 0;
    while ((frame_on || cyc < m_earliest) && n < 2000) begin
      tick(); n++;
    end
    tick();
    checks++;
    if (n >= 2000) begin
      errors++; $display("FAIL drain_bound got=%0d cycles exp<2000", n);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
    repeat (5) tick();
  endtask

  task automatic test_single();
    int c0;
    clear_logs();
    frame_len = FRAME;
    data_v = {$urandom, $urandom};
    data_v[2*W +: W] = 8'hA5;
    req_v = 4'b0100;
    c0 = cyc;
    repeat (FRAME + GAP + 10) tick();
    checks++;
    if (g_idx.size() != 1 || g_idx[0] != 2 || g_cyc[0] != c0 + 1 || g_data[0] != 8'hA5) begin
      errors++; $display("FAIL single_grant got n=%0d exp one gnt[2] at %0d data a5",
                         g_idx.size(), c0 + 1);
    end
    checks++;
    if (d_idx.size() != 1 || d_idx[0] != 2 || d_cyc[0] != c0 + 2 + FRAME) begin
      errors++; $display("FAIL single_done got n=%0d exp one done[2] at %0d",
                         d_idx.size(), c0 + 2 + FRAME);
    end
    drain();
  endtask

  task automatic test_all_four();
    apply_reset(2);
    clear_logs();
    frame_len = FRAME;
    data_v = {$urandom, $urandom};
    repeat (4 * (FRAME + GAP + 2) + 3) begin
      req_v = '1;
      tick();
    end
    checks++;
    if (g_idx.size() != 5) begin
      errors++; $display("FAIL rr_count got=%0d exp=5", g_idx.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (g_idx[i] != i % N) begin
          errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, g_idx[i], i % N);
        end
        if (i > 0) begin
          checks++;
          if (g_cyc[i] - g_cyc[i-1] != FRAME + GAP + 2) begin
            errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d",
                               i, g_cyc[i] - g_cyc[i-1], FRAME + GAP + 2);
          end
        end
      end
    end
    drain();
  endtask

  task automatic test_busy();
    int c1;
    clear_logs();
    frame_len = 30;
    busy_force = 1;
    req_v = 4'b0010;
    repeat (20) tick();
    checks++;
    if (g_idx.size() != 0) begin
      errors++; $display("FAIL busy_hold got=%0d grants exp=0", g_idx.size());
    end
    busy_force = 0;
    c1 = cyc;
    repeat (3) tick();
    checks++;
    if (g_idx.size() != 1 || g_idx[0] != 1 || g_cyc[0] != c1 + 1) begin
      errors++; $display("FAIL busy_release got n=%0d exp gnt[1] at %0d", g_idx.size(), c1 + 1);
    end
    drain();
  endtask

  task automatic test_withdraw();
    clear_logs();
    frame_len = 25;
    busy_force = 1;
    req_v = 4'b1001;
    repeat (5) tick();
    req_v[3] = 1'b0;
    repeat (3) tick();
    busy_force = 0;
    repeat (25 + GAP + 20) tick();
    checks++;
    if (g_idx.size() != 1 || g_idx[0] != 0) begin
      errors++; $display("FAIL withdraw_gnt got n=%0d first=%0d exp only gnt[0]",
                         g_idx.size(), (g_idx.size() > 0) ? g_idx[0] : -1);
    end
    checks++;
    if (d_idx.size() != 1 || d_idx[0] != 0) begin
      errors++; $display("FAIL withdraw_done got n=%0d exp only done[0]", d_idx.size());
    end
    drain();
  endtask

  task automatic test_reset_midframe();
    frame_len = 100;
    data_v = {$urandom, $urandom};
    data_v[2*W +: W] = 8'h3C;
    req_v = 4'b0100;
    repeat (20) tick();
    apply_reset(2);
    clear_logs();
    data_v = {$urandom, $urandom};
    frame_len = 20;
    req_v = 4'b1010;
    repeat (5) tick();
    checks++;
    if (g_idx.size() != 1 || g_idx[0] != 1) begin
      errors++; $display("FAIL post_reset_gnt got n=%0d first=%0d exp gnt[1]",
                         g_idx.size(), (g_idx.size() > 0) ? g_idx[0] : -1);
    end
    drain();
  endtask

  task automatic test_random();
    clear_logs();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && $urandom_range(0, 7) == 0) begin
          req_v[i] = 1'b1;
          data_v[i*W +: W] = W'($urandom);
        end else if (req_v[i] && $urandom_range(0, 39) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      frame_len  = $urandom_range(1, 40);
      busy_force = ($urandom_range(0, 15) == 0);
      spur_en    = ($urandom_range(0, 3) == 0);
      tick();
    end
    checks++;
    if (g_idx.size() < 20) begin
      errors++; $display("FAIL random_activity got=%0d grants exp>=20", g_idx.size());
    end
    drain();
  endtask

`ifdef UART_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int c0;
    clear_logs();
    withhold = 1;
    req_v = 4'b0001;
    c0 = cyc;
    repeat (TO + GAP + 10) tick();
    checks++;
    if (err_cyc.size() != 1 || err_cyc[0] != c0 + 2 + TO) begin
      errors++; $display("FAIL timeout_err got n=%0d exp one pulse at %0d", err_cyc.size(), c0 + 2 + TO);
    end
    checks++;
    if (d_idx.size() != 1 || d_idx[0] != 0 || d_cyc[0] != c0 + 2 + TO) begin
      errors++; $display("FAIL timeout_done got n=%0d exp done[0] at %0d", d_idx.size(), c0 + 2 + TO);
    end
    withhold = 0;
    drain();
  endtask
`endif

  initial begin
    req_v = '0; data_v = '0; busy_force = 0; spur_en = 0; withhold = 0; frame_len = 10;
    e_gnt = '0; e_done = '0; e_start = 0; e_err = 0;
    test_reset();
    test_single();
    test_all_four();
    test_busy();
    test_withdraw();
    test_reset_midframe();
    test_random();
`ifdef UART_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
